// File: rtl/gradient_magnitude_pipe_if.sv
// Stream bundle for the gradient-magnitude stage: Sobel gradients in, saturated magnitudes out.
// Both sides use valid/ready: a beat transfers on a rising clk edge where valid && ready;
// once raised, valid and its payload stay put until that transfer happens.
interface gradient_magnitude_pipe_if #(
  parameter int GW    = 11,
  parameter int OW    = 8,
  parameter int LANES = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*GW-1:0]   gx;
  logic [LANES*GW-1:0]   gy;
  logic [1:0]            mode;
  logic [OW-1:0]         threshold;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OW-1:0]   mag;
  logic [LANES-1:0]      edge_flag;

  modport master (
    output in_valid, gx, gy, mode, threshold, out_ready,
    input  in_ready, out_valid, mag, edge_flag
  );

  modport slave (
    input  in_valid, gx, gy, mode, threshold, out_ready,
    output in_ready, out_valid, mag, edge_flag
  );
endinterface

// File: rtl/gradient_magnitude_pipe.sv
// Gradient magnitude stage: |gx|,|gy| -> selectable norm -> saturate + threshold flag,
// with a global-stall pipeline and a saturating count of clipped lane results.
module gradient_magnitude_pipe #(
  parameter int GW    = 11,
  parameter int OW    = 8,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sat_clr,
  gradient_magnitude_pipe_if.slave bus,
  output logic [15:0]              sat_count
);
  localparam int RW = GW + 1;
  localparam logic [RW-1:0] MAX_MAG = RW'((1 << OW) - 1);

  logic                v1_q, v2_q, v3_q, out_valid_q;
  logic [LANES*GW-1:0] gx1_q, gy1_q, ax2_q, ay2_q;
  logic [1:0]          mode1_q, mode2_q;
  logic [OW-1:0]       thr1_q, thr2_q, thr3_q;
  logic [LANES*RW-1:0] res3_q;
  logic [LANES*OW-1:0] mag_q;
  logic [LANES-1:0]    flag_q, sat_q;
  logic [15:0]         sat_count_q;

  logic                advance;
  logic [LANES*GW-1:0] ax_d, ay_d;
  logic [LANES*RW-1:0] res_d;
  logic [LANES*OW-1:0] mag_d;
  logic [LANES-1:0]    flag_d, sat_d;
  logic [RW-1:0]       a_l, b_l, mx_l, mn_l, res_l;
  logic [16:0]         sat_inc, sat_sum;
  logic [15:0]         sat_count_d;

  // One stall signal for every stage: the pipeline only moves when the output slot is free.
  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.mag       = mag_q;
  assign bus.edge_flag = flag_q;
  assign sat_count     = sat_count_q;

  // Two's-complement negate keeps -2^(GW-1) as 2^(GW-1) when read as unsigned.
  always_comb begin
    ax_d = '0;
    ay_d = '0;
    for (int i = 0; i < LANES; i++) begin
      ax_d[i*GW +: GW] = gx1_q[i*GW+GW-1] ? (~gx1_q[i*GW +: GW]) + GW'(1) : gx1_q[i*GW +: GW];
      ay_d[i*GW +: GW] = gy1_q[i*GW+GW-1] ? (~gy1_q[i*GW +: GW]) + GW'(1) : gy1_q[i*GW +: GW];
    end
  end

  always_comb begin
    res_d = '0;
    a_l   = '0;
    b_l   = '0;
    mx_l  = '0;
    mn_l  = '0;
    for (int i = 0; i < LANES; i++) begin
      a_l  = {1'b0, ax2_q[i*GW +: GW]};
      b_l  = {1'b0, ay2_q[i*GW +: GW]};
      mx_l = (a_l >= b_l) ? a_l : b_l;
      mn_l = (a_l >= b_l) ? b_l : a_l;
      case (mode2_q)
        2'd0:    res_d[i*RW +: RW] = a_l + b_l;
        2'd1:    res_d[i*RW +: RW] = mx_l;
        2'd2:    res_d[i*RW +: RW] = mx_l + (mn_l >> 1);
        default: res_d[i*RW +: RW] = (a_l + b_l) >> 1;
      endcase
    end
  end

  always_comb begin
    mag_d  = '0;
    flag_d = '0;
    sat_d  = '0;
    res_l  = '0;
    for (int i = 0; i < LANES; i++) begin
      res_l = res3_q[i*RW +: RW];
      if (res_l > MAX_MAG) begin
        mag_d[i*OW +: OW] = '1;
        sat_d[i]          = 1'b1;
      end else begin
        mag_d[i*OW +: OW] = res_l[OW-1:0];
      end
      flag_d[i] = (mag_d[i*OW +: OW] >= thr3_q);
    end
  end

  always_comb begin
    sat_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      sat_inc = sat_inc + 17'(sat_q[i]);
    end
    sat_sum     = {1'b0, sat_count_q} + sat_inc;
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid_q && bus.out_ready) begin
      sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      gx1_q       <= '0;
      gy1_q       <= '0;
      ax2_q       <= '0;
      ay2_q       <= '0;
      mode1_q     <= '0;
      mode2_q     <= '0;
      thr1_q      <= '0;
      thr2_q      <= '0;
      thr3_q      <= '0;
      res3_q      <= '0;
      mag_q       <= '0;
      flag_q      <= '0;
      sat_q       <= '0;
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
      if (advance) begin
        v1_q        <= bus.in_valid;
        gx1_q       <= bus.gx;
        gy1_q       <= bus.gy;
        mode1_q     <= bus.mode;
        thr1_q      <= bus.threshold;
        v2_q        <= v1_q;
        ax2_q       <= ax_d;
        ay2_q       <= ay_d;
        mode2_q     <= mode1_q;
        thr2_q      <= thr1_q;
        v3_q        <= v2_q;
        res3_q      <= res_d;
        thr3_q      <= thr2_q;
        out_valid_q <= v3_q;
        mag_q       <= mag_d;
        flag_q      <= flag_d;
        sat_q       <= sat_d;
      end
    end
  end
endmodule

// File: doc/gradient_magnitude_pipe.md
# gradient_magnitude_pipe

Pipelined, parametrised gradient-magnitude stage for the edge-detection datapath. It accepts signed horizontal/vertical Sobel gradients for LANES pixels per beat and computes a saturated unsigned magnitude per pixel in one of four selectable norms. It also produces a per-pixel edge flag against a programmable threshold and counts saturation events. It sits between the Sobel convolution stage and the output frame buffer, with valid/ready flow control on both sides.

## Interface
- GW, 11: signed gradient width per component.
- OW, 8: unsigned magnitude output width.
- LANES, 1: pixels processed per beat.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- mode  in  2  norm select, sampled with each accepted beat: 0 L1, 1 max, 2 approx-L2, 3 half-L1.
- threshold  in  OW  edge threshold, sampled with each accepted beat.
- sat_clr  in  1  synchronous clear of sat_count.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- gx  in  LANES*GW  signed x-gradients; lane i at bits [i*GW +: GW].
- gy  in  LANES*GW  signed y-gradients, same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- mag  out  LANES*OW  saturated magnitudes; lane i at [i*OW +: OW].
- edge_flag  out  LANES  per-lane flag: mag >= threshold.
- sat_count  out  16  number of lane results that saturated since reset/clear.

## Operation
- Three-stage pipeline S1/S2/S3, one valid bit per stage. Each stage carries the data, mode and threshold of its beat.
- S1, absolute value: ax = |gx|, ay = |gy|, each GW bits unsigned. The value -2^(GW-1) maps to 2^(GW-1) without wrap.
- S2, combine, result GW+1 bits unsigned:
  - mode 0: ax + ay.
  - mode 1: max(ax, ay).
  - mode 2: max + (min >> 1), truncating.
  - mode 3: (ax + ay) >> 1.
- S3, saturate and flag:
  - mag = min(result, 2^OW - 1).
  - edge_flag = (mag >= threshold), comparing the saturated value.
  - The lane saturates when result > 2^OW - 1.
- sat_count:
  - On each S3 output handshake (out_valid && out_ready), adds the number of saturating lanes.
  - Saturates at 16'hFFFF; no wrap.
  - sat_clr has priority over increment that cycle; the count becomes 0.
- Flow control uses a global stall: advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance is high, all stages shift. S1 loads in_valid && in_ready.
  - When advance is low, all stage registers hold.
- No beat is dropped or duplicated under any out_ready pattern.
- Reset:
  - All stage valid bits, out_valid, mag, edge_flag and sat_count go to 0.
  - Data inside the pipeline is discarded.
  - in_ready reads 1 in the cycle after reset deasserts.

## Timing
- Latency: a beat accepted at edge N appears on mag/edge_flag with out_valid=1 after edge N+3, provided out_ready stayed high.
- Throughput: one beat per cycle while out_ready=1.
- Outputs are registered. mag/edge_flag hold their value while out_valid && !out_ready.
- in_ready depends combinationally on out_ready; there is no other combinational input-to-output path.
- rst asserted mid-stream: on the next edge, out_valid=0 and sat_count=0, regardless of out_ready or sat_clr.
- out_ready low while the pipeline is empty: no stall occurs, because advance is high whenever out_valid is 0.

## Test plan
- GW=11, OW=8, LANES=1, mode 0, threshold 128: gx=200, gy=112 -> mag=255, edge_flag=1, sat_count=1, 3 cycles after acceptance.
- gx=-40, gy=30, threshold 50, one beat per mode 0/1/2/3 back-to-back:
  - mags 70, 40, 55, 35.
  - edge_flags 1, 0, 1, 0.
  - Results on consecutive cycles, in order.
- gx=-1024, gy=0, mode 1 -> mag=255, sat_count increments. gx=-262, gy=136, mode 2 -> 330 saturates to 255.
- Stream 10 beats with out_ready toggling pseudo-randomly:
  - Output sequence equals the input sequence exactly.
  - mag stays stable while stalled.
  - in_ready = 0 exactly when out_valid=1 && out_ready=0.
- LANES=4: lanes (5,5), (-300,0), (0,-1), (127,1), mode 0 -> mags 10, 255, 1, 128. sat_count +1.
- Assert rst with 3 beats in flight -> out_valid=0 the next cycle and no stale beat ever emerges. Assert sat_clr in the same cycle as a saturating handshake -> sat_count=0.
